hub_requester: RTL
==================

Name: hub_requester

Overview:
- Initiator side of the hub memory interface: arbitrates hub access among NUM_COGS cog request ports using the fixed round-robin hub slot.
- Converts byte/word/long accesses at byte addresses into long-addressed, byte-lane-enabled hub memory cycles.
- Returns aligned, zero-extended read data to the requesting cog.
- Sits between the cogs and the hub memory block; drives that block's w/wb/a/d and consumes its q.

Parameters:
- NUM_COGS, 8, number of request ports; power of two; slot counter width is log2(NUM_COGS).
- ADDR_W, 16, cog byte-address width; hub long address = addr[ADDR_W-1:2] (14 bits).

Ports:
- clk_cog  in  1  system clock; all logic on rising edge.
- res  in  1  asynchronous, active-high reset.
- ena_bus  in  1  hub enable; memory and slot counter advance only on edges where ena_bus=1.
- req  in  NUM_COGS  per-cog access request; level, held until ack.
- we  in  NUM_COGS  per-cog write strobe (1 = write).
- sz  in  2*NUM_COGS  per-cog size: 00 byte, 01 word, 10 long, 11 reserved (treated as long).
- addr  in  ADDR_W*NUM_COGS  per-cog byte address.
- wdata  in  32*NUM_COGS  per-cog write data, right-justified.
- ack  out  NUM_COGS  one-clk_cog pulse when the access completes.
- rdata  out  32  read data for the acked cog; valid while its ack is high, held after.
- mem_w  out  1  write enable to hub memory.
- mem_wb  out  4  byte-lane enables.
- mem_a  out  14  long address.
- mem_d  out  32  lane-replicated write data.
- mem_q  in  32  hub memory read data (registered inside memory, valid one ena_bus edge after address).

Behaviour:
- Reset (async, res=1): slot=0, busy=0, pend_v=0, ack=0, rdata=0; mem_w=0, mem_wb=0, mem_a=0, mem_d=0. Reset mid-access drops the in-flight access; no ack is issued for it.
- Slot counter: increments on each edge with ena_bus=1; wraps NUM_COGS-1 -> 0; holds otherwise.
- Issue (combinational from the current slot s): if req[s] && !busy[s], drive mem_* from cog s; otherwise mem_w=0, mem_wb=0, mem_a=0, mem_d=0.
- On the ena_bus edge that issues an access: set busy[s]; capture pending {cog=s, sz, addr[1:0], we}; set pend_v=1.
- Lane rules, byte: mem_wb = 1<<addr[1:0]; mem_d = {4{wdata[7:0]}}.
- Lane rules, word: mem_wb = addr[1] ? 1100 : 0011; mem_d = {2{wdata[15:0]}}; addr[0] ignored.
- Lane rules, long: mem_wb = 1111; mem_d = wdata; addr[1:0] ignored.
- ROM protection: mem_w = we[s] && addr[ADDR_W-1]==0. Writes to ROM space (>= 0x8000) are suppressed but still acked.
- Completion: on the next ena_bus edge with pend_v=1:
  - rdata = lane of mem_q selected by pending addr/sz, zero-extended (byte: 24 zeros; word: 16 zeros; long: unchanged).
  - ack[cog]=1 for exactly one clk_cog cycle; busy[cog] cleared; pend_v cleared unless a new issue occurs on the same edge.
- Pipelining: issue and completion of different cogs on the same edge are legal. Total latency is 2 ena_bus edges from issue to ack.
- Write accesses also return rdata (the old memory value at that address). Only ack is contractual for writes.
- Requester protocol: hold req/we/sz/addr/wdata stable until ack; drop or change req in the cycle after ack. busy prevents reissue if req stays high on the ack cycle.
- ena_bus=0 on all edges: no issue, no completion, outputs hold.

Decomposition:
- Shared package (hub_pkg): SZ_BYTE=2'b00, SZ_WORD=2'b01, SZ_LONG=2'b10; HUB_LONG_AW=14; ROM_BASE bit index.
- Sub-module hub_lane_align (combinational): {sz, addr[1:0], wdata} -> {wb, d}, and {sz, addr[1:0], q} -> extended rdata.
- The top level holds the slot counter, busy bits, pending register and ack logic.

Test Plan:
- Reset: hold res=1 with req=8'hFF -> ack=0, mem_w=0, mem_wb=0, rdata=0; release -> slot starts at 0.
- Byte write: cog 3 writes byte 0xA5 to addr 0x0102, ena_bus every cycle -> in slot 3, mem_a=0x0040, mem_wb=0100, mem_d=0xA5A5A5A5; ack[3] pulses after 2 ena_bus edges.
- Word read: preload long 0x0040 = 0x11223344; cog 5 reads word at 0x0102 -> rdata=0x00001122 with ack[5].
- ROM write: cog 0 long write to 0x8000 -> mem_w=0, mem_wb=1111, ack[0] still pulses.
- Concurrency: all 8 cogs request long reads with ena_bus every other cycle -> acks arrive in slot order 0..7, each one cycle wide, no duplicates, rdata correct per cog.
- Reset during access: assert res between issue and completion -> no ack; after release the same request reissues and acks normally.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared definitions for the hub requester: access sizes, hub geometry
// and the read-lane selection helper.
package hub_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_LONG = 2'b10,
    SZ_RSVD = 2'b11
  } hub_sz_e;

  localparam int HUB_LONG_AW = 14;
  localparam int ROM_BIT     = 15;

  typedef struct packed {
    logic [1:0] sz;
    logic [1:0] lane;
  } hub_pend_t;

  function automatic logic [7:0] byte_lane(input logic [31:0] v, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = v[7:0];
      2'd1:    b = v[15:8];
      2'd2:    b = v[23:16];
      default: b = v[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/hub_requester_if.sv
// Cog request ports plus hub memory port of the hub requester.
// master = cogs/memory environment, slave = the requester itself.
interface hub_requester_if #(
  parameter int NUM_COGS = 8,
  parameter int ADDR_W   = 16
);
  import hub_pkg::*;

  logic                       ena_bus;
  logic [NUM_COGS-1:0]        req;
  logic [NUM_COGS-1:0]        we;
  logic [2*NUM_COGS-1:0]      sz;
  logic [ADDR_W*NUM_COGS-1:0] addr;
  logic [32*NUM_COGS-1:0]     wdata;
  logic [NUM_COGS-1:0]        ack;
  logic [31:0]                rdata;
  logic                       mem_w;
  logic [3:0]                 mem_wb;
  logic [HUB_LONG_AW-1:0]     mem_a;
  logic [31:0]                mem_d;
  logic [31:0]                mem_q;

  modport master (
    output ena_bus, req, we, sz, addr, wdata, mem_q,
    input  ack, rdata, mem_w, mem_wb, mem_a, mem_d
  );

  modport slave (
    input  ena_bus, req, we, sz, addr, wdata, mem_q,
    output ack, rdata, mem_w, mem_wb, mem_a, mem_d
  );

endinterface

// File: rtl/hub_lane_align.sv
// Byte-lane steering: write enables/replicated data for an outgoing access,
// and lane extraction with zero extension for returning read data.
module hub_lane_align
  import hub_pkg::*;
(
  input  logic [1:0]  i_wr_sz,
  input  logic [1:0]  i_wr_lane,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_wb,
  output logic [31:0] o_d,
  input  logic [1:0]  i_rd_sz,
  input  logic [1:0]  i_rd_lane,
  input  logic [31:0] i_q,
  output logic [31:0] o_rdata
);

  // write lane enables and replicated write data
  always_comb begin
    o_wb = 4'b0000;
    o_d  = 32'h0000_0000;
    case (i_wr_sz)
      SZ_BYTE: begin
        o_wb = 4'b0001 << i_wr_lane;
        o_d  = {4{i_wdata[7:0]}};
      end
      SZ_WORD: begin
        o_wb = i_wr_lane[1] ? 4'b1100 : 4'b0011;
        o_d  = {2{i_wdata[15:0]}};
      end
      default: begin
        o_wb = 4'b1111;
        o_d  = i_wdata;
      end
    endcase
  end

  // read lane selection, zero-extended
  always_comb begin
    o_rdata = 32'h0000_0000;
    case (i_rd_sz)
      SZ_BYTE: o_rdata = {24'h00_0000, byte_lane(i_q, i_rd_lane)};
      SZ_WORD: o_rdata = {16'h0000, (i_rd_lane[1] ? i_q[31:16] : i_q[15:0])};
      default: o_rdata = i_q;
    endcase
  end

endmodule

// File: rtl/hub_requester.sv
// Round-robin hub initiator: one cog slot per ena_bus edge, access issued in
// the slot, completed (ack + aligned rdata) on the following ena_bus edge.
module hub_requester
  import hub_pkg::*;
#(
  parameter int NUM_COGS = 8,
  parameter int ADDR_W   = 16
) (
  input logic           clk_cog,
  input logic           res,
  hub_requester_if.slave bus
);

  localparam int SW = $clog2(NUM_COGS);

  logic [SW-1:0]       r_slot;
  logic [NUM_COGS-1:0] r_busy;
  logic [NUM_COGS-1:0] r_ack;
  logic                r_pend_v;
  logic [SW-1:0]       r_pend_cog;
  hub_pend_t           r_pend;
  logic [31:0]         r_rdata;

  logic [31:0]         w_slot_i;
  logic [1:0]          w_sz;
  logic [ADDR_W-1:0]   w_addr;
  logic [31:0]         w_wdata;
  logic                w_we;
  logic                w_issue;
  logic [3:0]          w_wb;
  logic [31:0]         w_d;
  logic [31:0]         w_rd_ext;
  logic [NUM_COGS-1:0] w_busy_nxt;

  assign w_slot_i = 32'(r_slot);
  assign w_sz     = bus.sz[w_slot_i*32'd2 +: 2];
  assign w_addr   = bus.addr[w_slot_i*32'(ADDR_W) +: ADDR_W];
  assign w_wdata  = bus.wdata[w_slot_i*32'd32 +: 32];
  assign w_we     = bus.we[r_slot];
  // res gates issue so the memory port stays quiet while reset is held
  assign w_issue  = !res && bus.req[r_slot] && !r_busy[r_slot];

  hub_lane_align u_align (
    .i_wr_sz   (w_sz),
    .i_wr_lane (w_addr[1:0]),
    .i_wdata   (w_wdata),
    .o_wb      (w_wb),
    .o_d       (w_d),
    .i_rd_sz   (r_pend.sz),
    .i_rd_lane (r_pend.lane),
    .i_q       (bus.mem_q),
    .o_rdata   (w_rd_ext)
  );

  assign bus.mem_w  = w_issue && w_we && !w_addr[ROM_BIT];
  assign bus.mem_wb = w_issue ? w_wb : 4'b0000;
  assign bus.mem_a  = w_issue ? w_addr[ADDR_W-1:2] : {HUB_LONG_AW{1'b0}};
  assign bus.mem_d  = w_issue ? w_d : 32'h0000_0000;
  assign bus.ack    = r_ack;
  assign bus.rdata  = r_rdata;

  // busy bits after this edge: completing cog released, issuing cog claimed
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_pend_v) begin
      w_busy_nxt[r_pend_cog] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (w_issue) begin
      w_busy_nxt[r_slot] = 1'b1;
    end else begin
      w_busy_nxt[r_slot] = w_busy_nxt[r_slot];
    end
  end

  // slot counter, pending access and completion
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      r_slot     <= {SW{1'b0}};
      r_busy     <= {NUM_COGS{1'b0}};
      r_ack      <= {NUM_COGS{1'b0}};
      r_pend_v   <= 1'b0;
      r_pend_cog <= {SW{1'b0}};
      r_pend     <= '0;
      r_rdata    <= 32'h0000_0000;
    end else begin
      r_ack <= {NUM_COGS{1'b0}};
      if (bus.ena_bus) begin
        r_slot <= r_slot + {{(SW-1){1'b0}}, 1'b1};
        r_busy <= w_busy_nxt;
        if (r_pend_v) begin
          r_rdata           <= w_rd_ext;
          r_ack[r_pend_cog] <= 1'b1;
        end
        if (w_issue) begin
          r_pend_v    <= 1'b1;
          r_pend_cog  <= r_slot;
          r_pend.sz   <= w_sz;
          r_pend.lane <= w_addr[1:0];
        end else begin
          r_pend_v <= 1'b0;
        end
      end
    end
  end

endmodule
